// File: rtl/branch_predict_ctrl_pkg.sv
// Shared types and constants for the branch predictor and its recovery sequencer.
package branch_predict_ctrl_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RECOVER = 1'b1
    } state_t;

    localparam logic [1:0] STRONG_NT = 2'b00;
    localparam logic [1:0] WEAK_NT   = 2'b01;
    localparam logic [1:0] STRONG_T  = 2'b11;

    localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/branch_predict_ctrl_sat_counter2.sv
// Next value of a 2-bit saturating direction counter: count up on taken, down on not-taken.
module sat_counter2
    import branch_predict_ctrl_pkg::*;
(
    input  logic [1:0] i_cnt,
    input  logic       i_inc,
    output logic [1:0] o_next
);

    always_comb begin
        o_next = i_cnt;
        if (i_inc) begin
            if (i_cnt != STRONG_T) o_next = i_cnt + 2'd1;
        end else begin
            if (i_cnt != STRONG_NT) o_next = i_cnt - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predict_ctrl.sv
// 2-bit counter branch predictor with a one-cycle redirect/flush sequencer on mispredict.
module branch_predict_ctrl
    import branch_predict_ctrl_pkg::*;
#(
    parameter int PC_W  = 64,
    parameter int IDX_W = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_valid,
    input  logic             if_is_branch,
    input  logic [PC_W-1:0]  if_pc,
    output logic             pred_taken,
    input  logic             ex_valid,
    input  logic             ex_branch,
    input  logic [PC_W-1:0]  ex_pc,
    input  logic             ex_pred_taken,
    input  logic             ex_taken,
    input  logic [PC_W-1:0]  ex_target,
    output logic             redirect_valid,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             flush_exmem,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);

    localparam int N_ENT = 2 ** IDX_W;

    logic [1:0]       r_table [N_ENT];
    state_t           r_state;
    state_t           w_state_next;
    logic             r_redirect_valid;
    logic [PC_W-1:0]  r_redirect_pc;
    logic             r_flush;
    logic [CNT_W-1:0] r_br_count;
    logic [CNT_W-1:0] r_mispred_count;

    logic [IDX_W-1:0] w_if_idx;
    logic [IDX_W-1:0] w_ex_idx;
    logic [1:0]       w_ex_next;
    logic             w_resolve;
    logic             w_mispredict;
    logic             w_unused_pc;

    assign w_if_idx     = if_pc[IDX_W+1:2];
    assign w_ex_idx     = ex_pc[IDX_W+1:2];
    assign w_unused_pc  = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0]};

    // Resolution is ignored while recovering: EX then holds a wrong-path instruction.
    assign w_resolve    = ex_valid & ex_branch & (r_state == ST_IDLE);
    assign w_mispredict = w_resolve & (ex_pred_taken != ex_taken);

    assign pred_taken   = if_valid & if_is_branch & r_table[w_if_idx][1];

    sat_counter2 u_sat (
        .i_cnt  (r_table[w_ex_idx]),
        .i_inc  (ex_taken),
        .o_next (w_ex_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_ENT; i++) r_table[i] <= WEAK_NT;
        end else if (w_resolve) begin
            r_table[w_ex_idx] <= w_ex_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_mispredict) w_state_next = ST_RECOVER;
            ST_RECOVER: w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_flush          <= 1'b0;
            r_br_count       <= '0;
            r_mispred_count  <= '0;
        end else begin
            r_redirect_valid <= w_mispredict;
            r_flush          <= w_mispredict;
            if (w_mispredict)
                r_redirect_pc <= ex_taken ? ex_target : ex_pc + PC_W'(INSTR_BYTES);
            if (w_resolve && (r_br_count != {CNT_W{1'b1}}))
                r_br_count <= r_br_count + 1'b1;
            if (w_mispredict && (r_mispred_count != {CNT_W{1'b1}}))
                r_mispred_count <= r_mispred_count + 1'b1;
        end
    end

    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign flush_ifid     = r_flush;
    assign flush_idex     = r_flush;
    assign flush_exmem    = r_flush;
    assign br_count       = r_br_count;
    assign mispred_count  = r_mispred_count;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed vector bench for branch_predict_ctrl: prediction, table update, recovery and reset.
module tb_branch_predict_ctrl;

    logic        clk;
    logic        reset;
    logic        if_valid;
    logic        if_is_branch;
    logic [63:0] if_pc;
    logic        pred_taken;
    logic        ex_valid;
    logic        ex_branch;
    logic [63:0] ex_pc;
    logic        ex_pred_taken;
    logic        ex_taken;
    logic [63:0] ex_target;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        flush_ifid;
    logic        flush_idex;
    logic        flush_exmem;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    int n_cmp = 0;
    int n_mis = 0;

    branch_predict_ctrl #(.PC_W(64), .IDX_W(4), .CNT_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .if_valid       (if_valid),
        .if_is_branch   (if_is_branch),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .ex_valid       (ex_valid),
        .ex_branch      (ex_branch),
        .ex_pc          (ex_pc),
        .ex_pred_taken  (ex_pred_taken),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush_ifid     (flush_ifid),
        .flush_idex     (flush_idex),
        .flush_exmem    (flush_exmem),
        .br_count       (br_count),
        .mispred_count  (mispred_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ifv;
        logic        ifb;
        logic [63:0] ifpc;
        logic        exv;
        logic        exb;
        logic [63:0] expc;
        logic        exp_p;
        logic        ext;
        logic [63:0] extgt;
        logic        e_pred;
        logic        e_rv;
        logic [63:0] e_rpc;
        logic        e_fl;
        logic [31:0] e_br;
        logic [31:0] e_mis;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic clear_ex();
        ex_valid      = 1'b0;
        ex_branch     = 1'b0;
        ex_pc         = '0;
        ex_pred_taken = 1'b0;
        ex_taken      = 1'b0;
        ex_target     = '0;
    endtask

    // Correctly predicted resolve (pred == outcome), so only the table and br_count move.
    task automatic resolve_ok(input logic [63:0] pc, input logic tk);
        if_valid      = 1'b0;
        if_is_branch  = 1'b0;
        ex_valid      = 1'b1;
        ex_branch     = 1'b1;
        ex_pc         = pc;
        ex_pred_taken = tk;
        ex_taken      = tk;
        ex_target     = pc + 64'h40;
        @(posedge clk);
        #1;
        clear_ex();
    endtask

    initial begin
        reset = 1'b1; if_valid = 1'b0; if_is_branch = 1'b0; if_pc = '0;
        clear_ex();

        //           rst ifv ifb ifpc     exv exb expc     pp tk target   pred rv rpc      fl br mis
        vq.push_back('{1, 0, 0, 64'h0,   0, 0, 64'h0,   0, 0, 64'h0,   0, 0, 64'h0,   0, 0, 0});
        vq.push_back('{0, 1, 1, 64'h100, 0, 0, 64'h0,   0, 0, 64'h0,   0, 0, 64'h0,   0, 0, 0});
        vq.push_back('{0, 1, 1, 64'h100, 1, 1, 64'h100, 0, 1, 64'h200, 0, 1, 64'h200, 1, 1, 1});
        vq.push_back('{0, 1, 1, 64'h100, 1, 1, 64'h100, 0, 1, 64'h200, 1, 0, 64'h200, 0, 1, 1});
        vq.push_back('{0, 1, 1, 64'h100, 1, 1, 64'h100, 1, 1, 64'h200, 1, 0, 64'h200, 0, 2, 1});
        vq.push_back('{0, 1, 1, 64'h100, 1, 1, 64'h100, 1, 1, 64'h200, 1, 0, 64'h200, 0, 3, 1});
        vq.push_back('{0, 1, 1, 64'h100, 0, 0, 64'h0,   0, 0, 64'h0,   1, 0, 64'h200, 0, 3, 1});
        vq.push_back('{0, 1, 1, 64'h100, 1, 1, 64'h100, 0, 0, 64'h200, 1, 0, 64'h200, 0, 4, 1});
        vq.push_back('{0, 1, 1, 64'h100, 0, 0, 64'h0,   0, 0, 64'h0,   1, 0, 64'h200, 0, 4, 1});
        vq.push_back('{0, 1, 1, 64'h104, 1, 1, 64'h104, 1, 0, 64'h300, 0, 1, 64'h108, 1, 5, 2});
        vq.push_back('{0, 1, 1, 64'h104, 1, 1, 64'h104, 1, 0, 64'h300, 0, 0, 64'h108, 0, 5, 2});
        vq.push_back('{0, 0, 0, 64'h0,   1, 1, 64'h108, 0, 1, 64'h400, 0, 1, 64'h400, 1, 6, 3});
        vq.push_back('{0, 0, 0, 64'h0,   0, 0, 64'h0,   0, 0, 64'h0,   0, 0, 64'h400, 0, 6, 3});
        vq.push_back('{0, 1, 1, 64'h100, 1, 1, 64'h140, 0, 0, 64'h0,   1, 0, 64'h400, 0, 7, 3});
        vq.push_back('{0, 1, 1, 64'h100, 0, 0, 64'h0,   0, 0, 64'h0,   0, 0, 64'h400, 0, 7, 3});
        vq.push_back('{0, 1, 0, 64'h108, 1, 0, 64'h108, 0, 1, 64'h600, 0, 0, 64'h400, 0, 7, 3});
        vq.push_back('{0, 1, 1, 64'h108, 0, 1, 64'h108, 0, 1, 64'h600, 1, 0, 64'h400, 0, 7, 3});
        vq.push_back('{0, 0, 0, 64'h0,   1, 1, 64'h104, 0, 1, 64'h500, 0, 1, 64'h500, 1, 8, 4});
        vq.push_back('{1, 0, 0, 64'h0,   1, 1, 64'h104, 0, 1, 64'h500, 0, 0, 64'h0,   0, 0, 0});
        vq.push_back('{0, 1, 1, 64'h108, 0, 0, 64'h0,   0, 0, 64'h0,   0, 0, 64'h0,   0, 0, 0});
        vq.push_back('{1, 0, 0, 64'h0,   1, 1, 64'h100, 0, 1, 64'h200, 0, 0, 64'h0,   0, 0, 0});
        vq.push_back('{0, 1, 1, 64'h100, 0, 0, 64'h0,   0, 0, 64'h0,   0, 0, 64'h0,   0, 0, 0});

        foreach (vq[i]) begin
            reset         = vq[i].rst;
            if_valid      = vq[i].ifv;
            if_is_branch  = vq[i].ifb;
            if_pc         = vq[i].ifpc;
            ex_valid      = vq[i].exv;
            ex_branch     = vq[i].exb;
            ex_pc         = vq[i].expc;
            ex_pred_taken = vq[i].exp_p;
            ex_taken      = vq[i].ext;
            ex_target     = vq[i].extgt;
            #1;
            if (i > 0) chk("pred_taken", i, 64'(pred_taken), 64'(vq[i].e_pred));
            @(posedge clk);
            #1;
            chk("redirect_valid", i, 64'(redirect_valid), 64'(vq[i].e_rv));
            chk("redirect_pc",    i, redirect_pc,         vq[i].e_rpc);
            chk("flush_ifid",     i, 64'(flush_ifid),     64'(vq[i].e_fl));
            chk("flush_idex",     i, 64'(flush_idex),     64'(vq[i].e_fl));
            chk("flush_exmem",    i, 64'(flush_exmem),    64'(vq[i].e_fl));
            chk("br_count",       i, 64'(br_count),       64'(vq[i].e_br));
            chk("mispred_count",  i, 64'(mispred_count),  64'(vq[i].e_mis));
        end

        // Walk index 3 down to strong not-taken and hold it there, then climb back.
        for (int k = 0; k < 3; k++) resolve_ok(64'h10C, 1'b0);
        resolve_ok(64'h10C, 1'b1);
        if_valid = 1'b1; if_is_branch = 1'b1; if_pc = 64'h10C;
        #1;
        chk("sat_low_pred", 100, 64'(pred_taken), 64'd0);
        resolve_ok(64'h10C, 1'b1);
        if_valid = 1'b1; if_is_branch = 1'b1; if_pc = 64'h10C;
        #1;
        chk("climb_pred",     101, 64'(pred_taken),     64'd1);
        chk("walk_br_count",  101, 64'(br_count),       64'd5);
        chk("walk_mispred",   101, 64'(mispred_count),  64'd0);
        chk("walk_redirect",  101, 64'(redirect_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
